// File: rtl/demux_sel_ctrl_pkg.sv
// Shared definitions for the demux select sequencer: sequencer states and channel count.
package demux_sel_ctrl_pkg;

    localparam int N_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/demux_bh.sv
// Behavioural 2-to-4 demux driven by the select sequencer: line {b,a} follows en.
module demux_bh (
    input  logic       a,
    input  logic       b,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[{b, a}] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_sel_ctrl_rr_pick4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 3->0.
module rr_pick4
    import demux_sel_ctrl_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      winner,
    output logic            any
);

    logic [1:0]      w_idx [N_CH];
    logic [N_CH-1:0] w_rot;
    logic [1:0]      w_off;

    // Rotate requests so that bit 0 of w_rot is the channel at the pointer.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
        assign w_idx[gi] = ptr + 2'(gi);
        assign w_rot[gi] = req[w_idx[gi]];
    end

    always_comb begin
        w_off = 2'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 2'(i);
            end
        end
    end

    assign winner = ptr + w_off;
    assign any    = |req;

endmodule

// File: rtl/demux_sel_ctrl.sv
// Round-robin select sequencer for demux_bh: break-before-make select changes, DWELL-cycle grants.
module demux_sel_ctrl
    import demux_sel_ctrl_pkg::*;
#(
    parameter  int DWELL = 4,
    localparam int CNT_W = $clog2(DWELL + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic            a,
    output logic            b,
    output logic            en,
    output logic            busy,
    output logic            done,
    output logic [1:0]      grant_id
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic             r_en;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_ptr_next;
    logic [1:0]       w_sel_next;
    logic             w_en_next;
    logic             w_busy_next;
    logic             w_done_next;

    logic [1:0]       w_winner;
    logic             w_any;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // Outputs are computed for the state being entered so that they are all registered.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_sel_next   = r_sel;
        w_en_next    = 1'b0;
        w_busy_next  = 1'b1;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_sel_next   = w_winner;
                    w_state_next = ST_SETUP;
                end else begin
                    w_busy_next = 1'b0;
                end
            end
            ST_SETUP: begin
                w_cnt_next   = CNT_W'(DWELL - 1);
                w_en_next    = 1'b1;
                w_state_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (r_cnt == '0) begin
                    w_done_next  = 1'b1;
                    w_ptr_next   = r_sel + 2'd1;
                    w_state_next = ST_GAP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    w_en_next  = 1'b1;
                end
            end
            ST_GAP: begin
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_sel   <= w_sel_next;
            r_en    <= w_en_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign {b, a}   = r_sel;
    assign grant_id = r_sel;
    assign en       = r_en;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_demux_sel_ctrl.sv
// Randomized bench for demux_sel_ctrl (DWELL=4 and DWELL=1) against a grant-timeline model.
module tb_demux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [1:0] a_o, b_o, en_o, busy_o, done_o;
    logic [1:0] gid_o [2];
    logic [3:0] y_o   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pos = -1 when idle, else cycles since the arbitration edge (0 = select set up).
    int         pos [2];
    logic [1:0] win [2];
    logic [1:0] ptr [2];

    always #5 clk = ~clk;

    demux_sel_ctrl #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .a(a_o[0]), .b(b_o[0]), .en(en_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .grant_id(gid_o[0])
    );
    demux_bh u_dmx4 (.a(a_o[0]), .b(b_o[0]), .en(en_o[0]), .y(y_o[0]));

    demux_sel_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .a(a_o[1]), .b(b_o[1]), .en(en_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .grant_id(gid_o[1])
    );
    demux_bh u_dmx1 (.a(a_o[1]), .b(b_o[1]), .en(en_o[1]), .y(y_o[1]));

    function automatic int dw(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pos[m] = -1;
            win[m] = 2'd0;
            ptr[m] = 2'd0;
        end
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic       found;
        logic [1:0] c;
        for (int m = 0; m < 2; m++) begin
            if (pos[m] >= 0) begin
                pos[m] = (pos[m] == dw(m) + 1) ? -1 : pos[m] + 1;
            end else if (r != 4'd0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    c = ptr[m] + 2'(k);
                    if (!found && r[c]) begin
                        found  = 1'b1;
                        win[m] = c;
                    end
                end
                ptr[m] = win[m] + 2'd1;
                pos[m] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic       e_en, e_done, e_busy;
        logic [3:0] e_y;
        string      p;
        for (int m = 0; m < 2; m++) begin
            p      = (m == 0) ? "dw4" : "dw1";
            e_en   = (pos[m] >= 1) && (pos[m] <= dw(m));
            e_done = (pos[m] == dw(m) + 1);
            e_busy = (pos[m] >= 0);
            e_y    = e_en ? (4'b0001 << win[m]) : 4'b0000;
            chk({p, "_sel"},  32'({b_o[m], a_o[m]}), 32'(win[m]));
            chk({p, "_gid"},  32'(gid_o[m]),         32'(win[m]));
            chk({p, "_en"},   32'(en_o[m]),          32'(e_en));
            chk({p, "_busy"}, 32'(busy_o[m]),        32'(e_busy));
            chk({p, "_done"}, 32'(done_o[m]),        32'(e_done));
            chk({p, "_y"},    32'(y_o[m]),           32'(e_y));
        end
    endtask

    // Called at a falling edge: drive req, advance model at the rising edge, check at the next falling edge.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [3:0] hold_r;
        rst = 1'b1;
        req = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        repeat (20) cycle(4'b0000);

        cycle(4'b0100);
        repeat (10) cycle(4'b0000);

        repeat (40) cycle(4'b1111);
        repeat (10) cycle(4'b0000);

        cycle(4'b0100);
        repeat (10) cycle(4'b0000);
        repeat (40) cycle(4'b0011);
        repeat (10) cycle(4'b0000);

        repeat (3) cycle(4'b0001);
        repeat (10) cycle(4'b0000);

        hold_r = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) hold_r = 4'($urandom_range(0, 15));
            cycle(hold_r);
        end

        repeat (12) cycle(4'b0000);
        cycle(4'b0001);
        for (int i = 0; i < 20 && pos[0] != 2; i++) cycle(4'b0001);
        chk("pre_rst_en", 32'(en_o[0]), 32'(1));
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_en",   32'(en_o[0]),            32'(0));
        chk("async_rst_sel",  32'({b_o[0], a_o[0]}),   32'(0));
        chk("async_rst_busy", 32'(busy_o[0]),          32'(0));
        chk("async_rst_y",    32'(y_o[0]),             32'(0));
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b1000);
        repeat (10) cycle(4'b0000);

        for (int i = 0; i < 300; i++) cycle(4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
